instr_encoder: RTL and testbench

Assembles symbolic instructions (mnemonic code plus register/immediate fields) into 32-bit MIPS machine words and writes them sequentially into instruction memory. It is the inverse of the pipeline's instruction decoder. It is used by the test/boot loader to build programs in IM without an external assembler. The `li` pseudo-instruction expands to a two-word `lui`/`ori` sequence. Output is a held-until-accepted write port with memory backpressure.

---
 rtl/instr_encoder_if.sv | 41 ++++
 rtl/instr_encoder.sv | 187 ++++++++++++++++++
 tb/tb_instr_encoder.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// ============================================================================
// Module  : instr_encoder_if
// Brief   : Instruction-offer, configuration and IM write-port bundle for
//           instr_encoder.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface instr_encoder_if #(
    parameter int ADDR_W = 10
);
    logic              cfg_load;
    logic [ADDR_W-1:0] cfg_base;
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_mn;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [4:0]        in_sa;
    logic [31:0]       in_imm;
    logic              im_we;
    logic              im_ready;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic [ADDR_W:0]   wr_count;
    logic              full;
    logic              ovf;

    modport slave (
        input  cfg_load, cfg_base, in_valid, in_mn, in_rs, in_rt, in_rd, in_sa, in_imm, im_ready,
        output in_ready, im_we, im_addr, im_wdata, wr_count, full, ovf
    );

    modport master (
        output cfg_load, cfg_base, in_valid, in_mn, in_rs, in_rt, in_rd, in_sa, in_imm, im_ready,
        input  in_ready, im_we, im_addr, im_wdata, wr_count, full, ovf
    );
endinterface

`default_nettype wire

// File: rtl/instr_encoder.sv
// ============================================================================
// Module  : instr_encoder
// Brief   : Encodes symbolic instructions into MIPS words and writes them
//           sequentially into IM; li expands to lui/ori.
// Revision: 1.0
// ============================================================================
`default_nettype none

module instr_encoder #(
    parameter int ADDR_W = 10
) (
    input  wire logic        clk,
    input  wire logic        rst,
    instr_encoder_if.slave   bus
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_EMIT     = 2'd1;
    localparam logic [1:0] c_EMIT_LI1 = 2'd2;
    localparam logic [1:0] c_EMIT_LI2 = 2'd3;

    localparam logic [ADDR_W:0] c_CAP_M1 = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [4:0]      c_MN_LI  = 5'd31;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nx;
    logic              r_we;
    logic [31:0]       r_wdata;
    logic [31:0]       r_lo;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W:0]   r_count;
    logic              r_full;
    logic              r_ovf;

    logic [31:0]       w_word;
    logic [31:0]       w_li_lo;
    logic              w_in_ready;
    logic              w_done;
    logic              w_last;
    logic              w_accept;
    logic              w_is_li;

    function automatic logic [31:0] f_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sa,
                                        input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sa, fn};
    endfunction

    function automatic logic [31:0] f_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Each mnemonic forwards only the fields its format uses; the rest stay zero.
    always_comb begin
        w_word  = 32'h0;
        w_li_lo = 32'h0;
        case (bus.in_mn)
            5'd0:  w_word = 32'h0;
            5'd1:  w_word = f_i(6'h23, bus.in_rs, bus.in_rt, bus.in_imm[15:0]);
            5'd2:  w_word = f_i(6'h2B, bus.in_rs, bus.in_rt, bus.in_imm[15:0]);
            5'd3:  w_word = f_i(6'h08, bus.in_rs, bus.in_rt, bus.in_imm[15:0]);
            5'd4:  w_word = f_i(6'h09, bus.in_rs, bus.in_rt, bus.in_imm[15:0]);
            5'd5:  w_word = f_i(6'h0D, bus.in_rs, bus.in_rt, bus.in_imm[15:0]);
            5'd6:  w_word = f_i(6'h0F, 5'd0, bus.in_rt, bus.in_imm[15:0]);
            5'd7:  w_word = f_i(6'h04, bus.in_rs, bus.in_rt, bus.in_imm[15:0]);
            5'd8:  w_word = f_i(6'h05, bus.in_rs, bus.in_rt, bus.in_imm[15:0]);
            5'd9:  w_word = {6'h02, bus.in_imm[25:0]};
            5'd10: w_word = {6'h03, bus.in_imm[25:0]};
            5'd11: w_word = f_i(6'h07, bus.in_rs, 5'd0, bus.in_imm[15:0]);
            5'd12: w_word = f_i(6'h06, bus.in_rs, 5'd0, bus.in_imm[15:0]);
            5'd13: w_word = f_i(6'h0A, bus.in_rs, bus.in_rt, bus.in_imm[15:0]);
            5'd14: w_word = f_i(6'h0B, bus.in_rs, bus.in_rt, bus.in_imm[15:0]);
            5'd15: w_word = f_r(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h24);
            5'd16: w_word = f_r(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h25);
            5'd17: w_word = f_r(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h26);
            5'd18: w_word = f_r(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h20);
            5'd19: w_word = f_r(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h21);
            5'd20: w_word = f_r(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h22);
            5'd21: w_word = f_r(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h23);
            5'd22: w_word = f_r(5'd0, bus.in_rt, bus.in_rd, bus.in_sa, 6'h00);
            5'd23: w_word = f_r(5'd0, bus.in_rt, bus.in_rd, bus.in_sa, 6'h02);
            5'd24: w_word = f_r(bus.in_rs, 5'd0, 5'd0, 5'd0, 6'h08);
            5'd25: w_word = f_r(bus.in_rs, 5'd0, bus.in_rd, 5'd0, 6'h09);
            5'd26: w_word = f_r(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h2A);
            5'd27: w_word = f_r(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h2B);
            5'd28: w_word = f_r(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h07);
            5'd29: w_word = f_i(6'h01, bus.in_rs, 5'h01, bus.in_imm[15:0]);
            5'd30: w_word = f_i(6'h01, bus.in_rs, 5'h00, bus.in_imm[15:0]);
            5'd31: begin
                w_word  = f_i(6'h0F, 5'd0, bus.in_rt, bus.in_imm[31:16]);
                w_li_lo = f_i(6'h0D, bus.in_rt, bus.in_rt, bus.in_imm[15:0]);
            end
        endcase
    end

    assign w_done   = r_we & bus.im_ready;
    assign w_last   = w_done & (r_count == c_CAP_M1);
    assign w_accept = bus.in_valid & w_in_ready;
    assign w_is_li  = (bus.in_mn == c_MN_LI);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        if (bus.cfg_load) begin
            w_state_nx = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) w_state_nx = w_is_li ? c_EMIT_LI1 : c_EMIT;
                end
                c_EMIT, c_EMIT_LI2: begin
                    if (w_done) begin
                        if (w_accept) w_state_nx = w_is_li ? c_EMIT_LI1 : c_EMIT;
                        else          w_state_nx = c_IDLE;
                    end
                end
                c_EMIT_LI1: begin
                    if (w_done) w_state_nx = w_last ? c_IDLE : c_EMIT_LI2;
                end
                default: w_state_nx = c_IDLE;
            endcase
        end
    end

    // Refuse a new word on the completion that fills IM so nothing is pending while full.
    always_comb begin
        w_in_ready = 1'b0;
        case (r_state)
            c_IDLE:             w_in_ready = 1'b1;
            c_EMIT, c_EMIT_LI2: w_in_ready = bus.im_ready & ~w_last;
            default:            w_in_ready = 1'b0;
        endcase
        w_in_ready = w_in_ready & ~r_full & ~bus.cfg_load;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_wdata <= 32'h0;
            r_lo    <= 32'h0;
            r_base  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (bus.cfg_load) begin
            r_we    <= 1'b0;
            r_base  <= bus.cfg_base;
            r_count <= '0;
            r_full  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_done) begin
                r_count <= r_count + 1'b1;
                if (w_last) r_full <= 1'b1;
                if (w_last && (r_state == c_EMIT_LI1)) r_ovf <= 1'b1;
            end
            if (w_accept) begin
                r_we    <= 1'b1;
                r_wdata <= w_word;
                r_lo    <= w_li_lo;
            end else if (w_done && (r_state == c_EMIT_LI1) && !w_last) begin
                r_wdata <= r_lo;
            end else if (w_done) begin
                r_we <= 1'b0;
            end
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.im_we    = r_we;
    assign bus.im_addr  = r_base + r_count[ADDR_W-1:0];
    assign bus.im_wdata = r_wdata;
    assign bus.wr_count = r_count;
    assign bus.full     = r_full;
    assign bus.ovf      = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ============================================================================
// Module  : tb_instr_encoder
// Brief   : Directed self-checking bench for instr_encoder.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_instr_encoder;

    logic clk;
    logic rst;
    logic rst_c;
    int   tests;
    int   fails;
    int   cw;

    instr_encoder_if #(.ADDR_W(10)) bus ();
    instr_encoder_if #(.ADDR_W(2))  cb ();

    instr_encoder #(.ADDR_W(10)) dut   (.clk(clk), .rst(rst),   .bus(bus));
    instr_encoder #(.ADDR_W(2))  dut_c (.clk(clk), .rst(rst_c), .bus(cb));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (cb.im_we && cb.im_ready) cw++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4:0] mn, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sa, input logic [31:0] imm);
        bus.in_valid = 1'b1; bus.in_mn = mn; bus.in_rs = rs; bus.in_rt = rt;
        bus.in_rd = rd; bus.in_sa = sa; bus.in_imm = imm;
        #1;
    endtask

    task automatic send_c(input logic [4:0] mn, input logic [4:0] rt, input logic [31:0] imm);
        cb.in_valid = 1'b1; cb.in_mn = mn; cb.in_rs = 5'd1; cb.in_rt = rt;
        cb.in_rd = 5'd3; cb.in_sa = 5'd0; cb.in_imm = imm;
        #1;
    endtask

    task automatic test_reset;
        tests++; if (bus.im_we !== 1'b0) begin fails++; $display("FAIL rst_we: got %b want 0", bus.im_we); end
        tests++; if (bus.im_addr !== 10'd0) begin fails++; $display("FAIL rst_addr: got %h want 0", bus.im_addr); end
        tests++; if (bus.im_wdata !== 32'h0) begin fails++; $display("FAIL rst_wdata: got %h want 0", bus.im_wdata); end
        tests++; if (bus.wr_count !== 11'd0) begin fails++; $display("FAIL rst_count: got %0d want 0", bus.wr_count); end
        tests++; if ({bus.full, bus.ovf} !== 2'b00) begin fails++; $display("FAIL rst_flags: got %b want 00", {bus.full, bus.ovf}); end
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_add;
        bus.cfg_load = 1'b1; bus.cfg_base = 10'd100;
        send(5'd18, 5'd1, 5'd2, 5'd3, 5'd7, 32'h0);
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL cfg_ready: got %b want 0", bus.in_ready); end
        bus.in_valid = 1'b0;
        tick;
        bus.cfg_load = 1'b0;
        tests++; if (bus.im_we !== 1'b0) begin fails++; $display("FAIL cfg_noacc: got we %b want 0", bus.im_we); end
        send(5'd18, 5'd1, 5'd2, 5'd3, 5'd7, 32'h0);
        tick;
        bus.in_valid = 1'b0;
        tests++; if (bus.im_we !== 1'b1) begin fails++; $display("FAIL add_we: got %b want 1", bus.im_we); end
        tests++; if (bus.im_addr !== 10'd100) begin fails++; $display("FAIL add_addr: got %0d want 100", bus.im_addr); end
        tests++; if (bus.im_wdata !== 32'h00221820) begin fails++; $display("FAIL add_data: got %h want 00221820", bus.im_wdata); end
        tick;
        tests++; if ({bus.im_we, bus.wr_count} !== {1'b0, 11'd1}) begin fails++; $display("FAIL add_done: got we %b cnt %0d want 0 1", bus.im_we, bus.wr_count); end
    endtask

    task automatic test_back_to_back;
        send(5'd5, 5'd0, 5'd8, 5'd0, 5'd0, 32'h1234);
        tick;
        tests++; if ({bus.im_addr, bus.im_wdata} !== {10'd101, 32'h34081234}) begin fails++; $display("FAIL ori: got %0d %h want 101 34081234", bus.im_addr, bus.im_wdata); end
        send(5'd22, 5'd0, 5'd3, 5'd2, 5'd4, 32'h0);
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready: got %b want 1", bus.in_ready); end
        tick;
        bus.in_valid = 1'b0;
        tests++; if ({bus.im_we, bus.im_addr, bus.im_wdata} !== {1'b1, 10'd102, 32'h00031100}) begin fails++; $display("FAIL sll: got %b %0d %h want 1 102 00031100", bus.im_we, bus.im_addr, bus.im_wdata); end
        tick;
        tests++; if ({bus.im_we, bus.wr_count} !== {1'b0, 11'd3}) begin fails++; $display("FAIL b2b_done: got we %b cnt %0d want 0 3", bus.im_we, bus.wr_count); end
    endtask

    task automatic test_li;
        send(5'd31, 5'd0, 5'd9, 5'd0, 5'd0, 32'hDEADBEEF);
        tick;
        tests++; if ({bus.im_addr, bus.im_wdata} !== {10'd103, 32'h3C09DEAD}) begin fails++; $display("FAIL li_hi: got %0d %h want 103 3C09DEAD", bus.im_addr, bus.im_wdata); end
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL li1_ready: got %b want 0", bus.in_ready); end
        bus.in_valid = 1'b0;
        tick;
        tests++; if ({bus.im_we, bus.im_addr, bus.im_wdata} !== {1'b1, 10'd104, 32'h3529BEEF}) begin fails++; $display("FAIL li_lo: got %b %0d %h want 1 104 3529BEEF", bus.im_we, bus.im_addr, bus.im_wdata); end
        tick;
        tests++; if ({bus.im_we, bus.wr_count} !== {1'b0, 11'd5}) begin fails++; $display("FAIL li_done: got we %b cnt %0d want 0 5", bus.im_we, bus.wr_count); end
    endtask

    task automatic test_branch_jump;
        send(5'd29, 5'd4, 5'd0, 5'd0, 5'd0, 32'h0000FFFE);
        tick;
        tests++; if ({bus.im_addr, bus.im_wdata} !== {10'd105, 32'h0481FFFE}) begin fails++; $display("FAIL bgez: got %0d %h want 105 0481FFFE", bus.im_addr, bus.im_wdata); end
        send(5'd9, 5'd0, 5'd0, 5'd0, 5'd0, 32'h00100000);
        tick;
        bus.in_valid = 1'b0;
        tests++; if ({bus.im_addr, bus.im_wdata} !== {10'd106, 32'h08100000}) begin fails++; $display("FAIL j: got %0d %h want 106 08100000", bus.im_addr, bus.im_wdata); end
        tick;
        tests++; if (bus.wr_count !== 11'd7) begin fails++; $display("FAIL bj_count: got %0d want 7", bus.wr_count); end
    endtask

    task automatic test_backpressure;
        bus.im_ready = 1'b0;
        send(5'd18, 5'd1, 5'd2, 5'd3, 5'd0, 32'h0);
        tick;
        send(5'd17, 5'd4, 5'd5, 5'd6, 5'd0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tests++; if ({bus.im_we, bus.im_addr, bus.im_wdata} !== {1'b1, 10'd107, 32'h00221820}) begin fails++; $display("FAIL bp_hold%0d: got %b %0d %h want 1 107 00221820", i, bus.im_we, bus.im_addr, bus.im_wdata); end
            tests++; if ({bus.in_ready, bus.wr_count} !== {1'b0, 11'd7}) begin fails++; $display("FAIL bp_stall%0d: got rdy %b cnt %0d want 0 7", i, bus.in_ready, bus.wr_count); end
            tick;
        end
        bus.in_valid = 1'b0;
        bus.im_ready = 1'b1;
        tick;
        tests++; if ({bus.im_we, bus.wr_count} !== {1'b0, 11'd8}) begin fails++; $display("FAIL bp_release: got we %b cnt %0d want 0 8", bus.im_we, bus.wr_count); end
    endtask

    task automatic test_capacity;
        cb.cfg_load = 1'b1; cb.cfg_base = 2'd3;
        tick;
        cb.cfg_load = 1'b0;
        send_c(5'd16, 5'd2, 32'h0);
        tick;
        tests++; if ({cb.im_we, cb.im_addr, cb.im_wdata} !== {1'b1, 2'd3, 32'h00221825}) begin fails++; $display("FAIL cap_w0: got %b %0d %h want 1 3 00221825", cb.im_we, cb.im_addr, cb.im_wdata); end
        tick;
        tests++; if (cb.im_addr !== 2'd0) begin fails++; $display("FAIL cap_w1: got %0d want 0", cb.im_addr); end
        tick;
        tests++; if (cb.im_addr !== 2'd1) begin fails++; $display("FAIL cap_w2: got %0d want 1", cb.im_addr); end
        send_c(5'd31, 5'd9, 32'h12345678);
        tick;
        cb.in_valid = 1'b0;
        tests++; if ({cb.im_addr, cb.im_wdata} !== {2'd2, 32'h3C091234}) begin fails++; $display("FAIL cap_lihi: got %0d %h want 2 3C091234", cb.im_addr, cb.im_wdata); end
        tick;
        tests++; if ({cb.im_we, cb.full, cb.ovf, cb.wr_count} !== {3'b011, 3'd4}) begin fails++; $display("FAIL cap_full: got we %b full %b ovf %b cnt %0d want 0 1 1 4", cb.im_we, cb.full, cb.ovf, cb.wr_count); end
        send_c(5'd16, 5'd2, 32'h0);
        tests++; if (cb.in_ready !== 1'b0) begin fails++; $display("FAIL cap_ready: got %b want 0", cb.in_ready); end
        tick;
        cb.in_valid = 1'b0;
        tick;
        tests++; if ({cb.im_we, cw} !== {1'b0, 32'd4}) begin fails++; $display("FAIL cap_writes: got we %b writes %0d want 0 4", cb.im_we, cw); end
        cb.cfg_load = 1'b1; cb.cfg_base = 2'd0;
        tick;
        cb.cfg_load = 1'b0;
        #1;
        tests++; if ({cb.full, cb.ovf, cb.wr_count, cb.in_ready} !== {2'b00, 3'd0, 1'b1}) begin fails++; $display("FAIL cap_clear: got full %b ovf %b cnt %0d rdy %b want 0 0 0 1", cb.full, cb.ovf, cb.wr_count, cb.in_ready); end
    endtask

    task automatic test_reset_mid_li;
        send_c(5'd31, 5'd9, 32'hDEADBEEF);
        tick;
        cb.in_valid = 1'b0;
        tests++; if ({cb.im_we, cb.im_wdata} !== {1'b1, 32'h3C09DEAD}) begin fails++; $display("FAIL rli_hi: got %b %h want 1 3C09DEAD", cb.im_we, cb.im_wdata); end
        rst_c = 1'b1;
        #1;
        tests++; if ({cb.im_we, cb.im_addr, cb.im_wdata} !== {1'b0, 2'd0, 32'h0}) begin fails++; $display("FAIL rli_out: got %b %0d %h want 0 0 0", cb.im_we, cb.im_addr, cb.im_wdata); end
        tests++; if ({cb.wr_count, cb.full, cb.ovf} !== {3'd0, 2'b00}) begin fails++; $display("FAIL rli_stat: got cnt %0d full %b ovf %b want 0 0 0", cb.wr_count, cb.full, cb.ovf); end
        tick;
        rst_c = 1'b0;
        tick;
        tick;
        tests++; if ({cb.im_we, cb.in_ready, cw} !== {2'b01, 32'd4}) begin fails++; $display("FAIL rli_after: got we %b rdy %b writes %0d want 0 1 4", cb.im_we, cb.in_ready, cw); end
    endtask

    initial begin
        tests = 0; fails = 0; cw = 0;
        rst = 1'b1; rst_c = 1'b1;
        bus.cfg_load = 1'b0; bus.cfg_base = '0; bus.in_valid = 1'b0; bus.in_mn = '0;
        bus.in_rs = '0; bus.in_rt = '0; bus.in_rd = '0; bus.in_sa = '0; bus.in_imm = '0;
        bus.im_ready = 1'b1;
        cb.cfg_load = 1'b0; cb.cfg_base = '0; cb.in_valid = 1'b0; cb.in_mn = '0;
        cb.in_rs = '0; cb.in_rt = '0; cb.in_rd = '0; cb.in_sa = '0; cb.in_imm = '0;
        cb.im_ready = 1'b1;
        tick;
        tick;
        rst = 1'b0; rst_c = 1'b0;
        #1;
        test_reset;
        test_add;
        test_back_to_back;
        test_li;
        test_branch_jump;
        test_backpressure;
        test_capacity;
        test_reset_mid_li;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
